mux_pipe_reg: RTL and testbench
===============================

Name: mux_pipe_reg

Overview:
Parametrised N-way, W-bit selector feeding a one-stage pipeline register with stall, flush and valid tracking.
- Generalises the fixed 4/8-input datapath muxes to arbitrary width and input count.
- Adds registered output, illegal-select detection and a sticky error flag.
- Sits at a pipeline boundary in the CPU datapath, e.g. forwarding source selection into the E/M stage register.

Parameters:
- WIDTH, 32, data width per input and output.
- N_IN, 8, number of inputs (2..32).
- RESET_VAL, 0, value of out_data after reset or flush, and the mux result for an illegal select.
- Derived, not overridable: SEL_W = $clog2(N_IN), with a minimum of 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  N_IN*WIDTH  packed inputs; input i occupies bits [i*WIDTH +: WIDTH].
- sel  in  SEL_W  binary select (N_IN bits when MUX_ONEHOT_EN is defined).
- in_valid  in  1  the current selection is meaningful.
- stall  in  1  hold the register contents.
- flush  in  1  clear the register (bubble insert).
- err_clr  in  1  clear the sticky error flag.
- out_data  out  WIDTH  registered selected data.
- out_valid  out  1  registered in_valid.
- out_sel  out  SEL_W  registered select value, for hazard and debug use.
- sel_err  out  1  sticky illegal-select flag.

Behaviour:
- Single clock; reset is asynchronous and active-low.
- Reset (rst_n=0, asynchronous, any time):
  - out_data=RESET_VAL; out_valid=0; out_sel=0; sel_err=0.
  - Takes effect immediately and overrides every other input, including mid-stall.
- Combinational mux result m:
  - m = in_data[sel] when sel < N_IN.
  - m = RESET_VAL when sel >= N_IN. This is only reachable when N_IN is not a power of two.
- Register update priority at each rising edge (rst_n=1): flush > stall > load.
  - flush=1: out_data<=RESET_VAL, out_valid<=0, out_sel<=0, even when stall=1.
  - stall=1 (no flush): all registers hold.
  - Otherwise (load): out_data<=m, out_valid<=in_valid, out_sel<=sel.
  - Latency is 1 cycle from sel/in_data to out_data. There is no combinational path from inputs to outputs.
- sel_err:
  - Sets on a load edge with in_valid=1 and an illegal sel.
  - Does not set on flush, stall, or load with in_valid=0.
  - err_clr=1 clears it on the edge.
  - A set and err_clr in the same cycle leaves sel_err=1 (set wins).
- out_data is loaded even when in_valid=0. Consumers qualify with out_valid.
- N_IN=2 uses a 1-bit sel; no illegal value exists.

Optional Feature:
MUX_ONEHOT_EN
- Defined:
  - sel is N_IN bits, one-hot.
  - m = in_data of the single set bit.
  - A zero or multi-hot sel is illegal: m=RESET_VAL and sel_err sets under the same load/in_valid rule.
  - out_sel holds the registered one-hot vector.
- Undefined: binary select as described above.

Test Plan:
1. Reset and load (N_IN=8, WIDTH=32, input i = 0x1000_0000+i):
   - Hold rst_n=0 for 3 cycles: all outputs are 0.
   - Release, then apply sel=5, in_valid=1: after 1 edge, out_data=0x1000_0005, out_valid=1, out_sel=5.
2. Stall then flush priority:
   - Load sel=3, then stall=1 for 4 cycles with sel=6: out_data stays 0x1000_0003.
   - Assert stall=1 and flush=1 together: next edge gives out_data=0, out_valid=0.
3. Illegal select (N_IN=6):
   - sel=7, in_valid=1: out_data=RESET_VAL and sel_err=1.
   - sel_err remains 1 across later legal loads.
   - err_clr=1 with a legal sel: sel_err=0 next edge.
   - err_clr=1 with sel=6, in_valid=1 in the same cycle: sel_err stays 1.
4. No false error:
   - sel=7 with in_valid=0, or with stall=1, or with flush=1: sel_err stays 0.
5. Asynchronous reset mid-operation:
   - With out_valid=1 and stall=1, pulse rst_n low between clock edges: outputs clear immediately, before the next edge.
6. One-hot build (MUX_ONEHOT_EN, N_IN=4):
   - sel=4'b0100: out_data = input 2.
   - sel=4'b0110, in_valid=1: out_data=RESET_VAL and sel_err=1.
   - sel=4'b0000, in_valid=1: out_data=RESET_VAL and sel_err=1.

Source files
------------

// File: rtl/mux_pipe_reg.sv
// mux_pipe_reg: N_IN-way WIDTH-bit selector feeding a one-stage pipeline register
// with stall, flush, valid tracking and a sticky illegal-select flag.
// Optional build macro MUX_ONEHOT_EN switches sel from binary to one-hot (N_IN bits).
module mux_pipe_reg #(
    parameter int              WIDTH     = 32,
    parameter int              N_IN      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
`ifdef MUX_ONEHOT_EN
    localparam int             SEL_W     = N_IN
`else
    localparam int             SEL_W     = (N_IN > 2) ? $clog2(N_IN) : 1
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  err_clr,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  sel_err
);

    logic [WIDTH-1:0] w_mux;
    logic             w_sel_ok;
    logic             w_load;
    logic             w_err_set;

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [SEL_W-1:0] r_sel;
    logic             r_sel_err;

`ifdef MUX_ONEHOT_EN
    // Zero or multi-hot selects are illegal and fall back to RESET_VAL.
    always_comb begin
        w_mux    = RESET_VAL;
        w_sel_ok = $onehot(sel);
        for (int i = 0; i < N_IN; i++) begin
            if (sel[i] && w_sel_ok) begin
                w_mux = in_data[i*WIDTH +: WIDTH];
            end
        end
    end
`else
    // Selects at or above N_IN exist only for non-power-of-two N_IN.
    always_comb begin
        w_mux    = RESET_VAL;
        w_sel_ok = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                w_mux    = in_data[i*WIDTH +: WIDTH];
                w_sel_ok = 1'b1;
            end
        end
    end
`endif

    assign w_load    = !flush && !stall;
    assign w_err_set = w_load && in_valid && !w_sel_ok;

    // Update priority: flush beats stall beats load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= RESET_VAL;
            r_valid <= 1'b0;
            r_sel   <= '0;
        end else if (flush) begin
            r_data  <= RESET_VAL;
            r_valid <= 1'b0;
            r_sel   <= '0;
        end else if (!stall) begin
            r_data  <= w_mux;
            r_valid <= in_valid;
            r_sel   <= sel;
        end
    end

    // A new illegal select outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err <= 1'b0;
        end else if (w_err_set) begin
            r_sel_err <= 1'b1;
        end else if (err_clr) begin
            r_sel_err <= 1'b0;
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_sel   = r_sel;
    assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_mux_pipe_reg.sv
// Self-checking bench for mux_pipe_reg; covers the binary build (N_IN=8 and N_IN=6)
// or, when MUX_ONEHOT_EN is defined, the one-hot build with N_IN=4.
module tb_mux_pipe_reg;

    localparam int WIDTH = 32;
`ifdef MUX_ONEHOT_EN
    localparam int NA = 4;
    localparam int SW = 4;
`else
    localparam int NA = 8;
    localparam int SW = 3;
`endif

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             valid;
        logic [SW-1:0]    sel;
        logic             err;
    } exp_t;

    typedef struct {
        logic [SW-1:0]    s;
        logic             v;
        logic             c;
        logic [WIDTH-1:0] d;
        logic             e;
    } row_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [NA*WIDTH-1:0] in_data;
    logic [SW-1:0] sel;
    logic in_valid;
    logic stall;
    logic flush;
    logic err_clr;

    logic [WIDTH-1:0] a_data;
    logic a_valid;
    logic [SW-1:0] a_sel;
    logic a_err;

    int checks = 0;
    int errors = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    mux_pipe_reg #(.WIDTH(WIDTH), .N_IN(NA), .RESET_VAL('0)) dutA (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel),
        .in_valid(in_valid), .stall(stall), .flush(flush), .err_clr(err_clr),
        .out_data(a_data), .out_valid(a_valid), .out_sel(a_sel), .sel_err(a_err)
    );

`ifndef MUX_ONEHOT_EN
    logic [WIDTH-1:0] b_data;
    logic b_valid;
    logic [SW-1:0] b_sel;
    logic b_err;

    mux_pipe_reg #(.WIDTH(WIDTH), .N_IN(6), .RESET_VAL('0)) dutB (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[6*WIDTH-1:0]), .sel(sel),
        .in_valid(in_valid), .stall(stall), .flush(flush), .err_clr(err_clr),
        .out_data(b_data), .out_valid(b_valid), .out_sel(b_sel), .sel_err(b_err)
    );
`endif

    task automatic test_reset();
        rst_n = 1'b0;
        sel = SW'(1);
        in_valid = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (a_data !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", a_data); end
        checks++; if (a_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", a_valid); end
        checks++; if (a_sel !== '0) begin errors++; $display("[TB] FAIL reset_sel: got %h expected 0", a_sel); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", a_err); end
        rst_n = 1'b1;
    endtask

`ifdef MUX_ONEHOT_EN
    task automatic test_onehot();
        row_t tbl[7];
        exp_t e;
        tbl[0] = '{s: 4'b0100, v: 1'b1, c: 1'b0, d: 32'h1000_0002, e: 1'b0};
        tbl[1] = '{s: 4'b0110, v: 1'b1, c: 1'b0, d: 32'h0000_0000, e: 1'b1};
        tbl[2] = '{s: 4'b0001, v: 1'b1, c: 1'b1, d: 32'h1000_0000, e: 1'b0};
        tbl[3] = '{s: 4'b0000, v: 1'b1, c: 1'b0, d: 32'h0000_0000, e: 1'b1};
        tbl[4] = '{s: 4'b1000, v: 1'b0, c: 1'b1, d: 32'h1000_0003, e: 1'b0};
        tbl[5] = '{s: 4'b0011, v: 1'b0, c: 1'b0, d: 32'h0000_0000, e: 1'b0};
        tbl[6] = '{s: 4'b0010, v: 1'b1, c: 1'b0, d: 32'h1000_0001, e: 1'b0};
        for (int k = 0; k < 7; k++) begin
            sel = tbl[k].s;
            in_valid = tbl[k].v;
            err_clr = tbl[k].c;
            sbq.push_back('{data: tbl[k].d, valid: tbl[k].v, sel: tbl[k].s, err: tbl[k].e});
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++; if (a_data !== e.data) begin errors++; $display("[TB] FAIL onehot_data[%0d]: got %h expected %h", k, a_data, e.data); end
            checks++; if (a_valid !== e.valid) begin errors++; $display("[TB] FAIL onehot_valid[%0d]: got %b expected %b", k, a_valid, e.valid); end
            checks++; if (a_sel !== e.sel) begin errors++; $display("[TB] FAIL onehot_sel[%0d]: got %b expected %b", k, a_sel, e.sel); end
            checks++; if (a_err !== e.err) begin errors++; $display("[TB] FAIL onehot_err[%0d]: got %b expected %b", k, a_err, e.err); end
        end
        err_clr = 1'b0;
    endtask
`else
    task automatic test_load();
        exp_t e;
        sel = 3'd5;
        in_valid = 1'b1;
        sbq.push_back('{data: 32'h1000_0005, valid: 1'b1, sel: 3'd5, err: 1'b0});
        @(posedge clk); #1;
        e = sbq.pop_front();
        checks++; if (a_data !== e.data) begin errors++; $display("[TB] FAIL load_data: got %h expected %h", a_data, e.data); end
        checks++; if (a_valid !== e.valid) begin errors++; $display("[TB] FAIL load_valid: got %b expected %b", a_valid, e.valid); end
        checks++; if (a_sel !== e.sel) begin errors++; $display("[TB] FAIL load_sel: got %h expected %h", a_sel, e.sel); end
        checks++; if (a_err !== e.err) begin errors++; $display("[TB] FAIL load_err: got %b expected %b", a_err, e.err); end
    endtask

    task automatic test_stall_flush();
        exp_t e;
        sel = 3'd3;
        in_valid = 1'b1;
        sbq.push_back('{data: 32'h1000_0003, valid: 1'b1, sel: 3'd3, err: 1'b0});
        @(posedge clk); #1;
        e = sbq.pop_front();
        checks++; if (a_data !== e.data) begin errors++; $display("[TB] FAIL pre_stall_data: got %h expected %h", a_data, e.data); end
        stall = 1'b1;
        sel = 3'd6;
        for (int k = 0; k < 4; k++) begin
            sbq.push_back('{data: 32'h1000_0003, valid: 1'b1, sel: 3'd3, err: 1'b0});
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++; if (a_data !== e.data) begin errors++; $display("[TB] FAIL stall_data[%0d]: got %h expected %h", k, a_data, e.data); end
            checks++; if (a_sel !== e.sel) begin errors++; $display("[TB] FAIL stall_sel[%0d]: got %h expected %h", k, a_sel, e.sel); end
        end
        flush = 1'b1;
        sbq.push_back('{data: 32'h0, valid: 1'b0, sel: 3'd0, err: 1'b0});
        @(posedge clk); #1;
        e = sbq.pop_front();
        checks++; if (a_data !== e.data) begin errors++; $display("[TB] FAIL flush_data: got %h expected %h", a_data, e.data); end
        checks++; if (a_valid !== e.valid) begin errors++; $display("[TB] FAIL flush_valid: got %b expected %b", a_valid, e.valid); end
        checks++; if (a_sel !== e.sel) begin errors++; $display("[TB] FAIL flush_sel: got %h expected %h", a_sel, e.sel); end
        stall = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_illegal();
        row_t tbl[7];
        exp_t e;
        tbl[0] = '{s: 3'd7, v: 1'b1, c: 1'b0, d: 32'h0000_0000, e: 1'b1};
        tbl[1] = '{s: 3'd2, v: 1'b1, c: 1'b0, d: 32'h1000_0002, e: 1'b1};
        tbl[2] = '{s: 3'd4, v: 1'b0, c: 1'b0, d: 32'h1000_0004, e: 1'b1};
        tbl[3] = '{s: 3'd1, v: 1'b1, c: 1'b1, d: 32'h1000_0001, e: 1'b0};
        tbl[4] = '{s: 3'd7, v: 1'b1, c: 1'b0, d: 32'h0000_0000, e: 1'b1};
        tbl[5] = '{s: 3'd6, v: 1'b1, c: 1'b1, d: 32'h0000_0000, e: 1'b1};
        tbl[6] = '{s: 3'd0, v: 1'b1, c: 1'b1, d: 32'h1000_0000, e: 1'b0};
        for (int k = 0; k < 7; k++) begin
            sel = tbl[k].s;
            in_valid = tbl[k].v;
            err_clr = tbl[k].c;
            sbq.push_back('{data: tbl[k].d, valid: tbl[k].v, sel: tbl[k].s, err: tbl[k].e});
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++; if (b_data !== e.data) begin errors++; $display("[TB] FAIL illegal_data[%0d]: got %h expected %h", k, b_data, e.data); end
            checks++; if (b_valid !== e.valid) begin errors++; $display("[TB] FAIL illegal_valid[%0d]: got %b expected %b", k, b_valid, e.valid); end
            checks++; if (b_sel !== e.sel) begin errors++; $display("[TB] FAIL illegal_sel[%0d]: got %h expected %h", k, b_sel, e.sel); end
            checks++; if (b_err !== e.err) begin errors++; $display("[TB] FAIL illegal_err[%0d]: got %b expected %b", k, b_err, e.err); end
        end
        err_clr = 1'b0;
    endtask

    task automatic test_no_false_error();
        sel = 3'd7;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (b_err !== 1'b0) begin errors++; $display("[TB] FAIL nofalse_invalid: got %b expected 0", b_err); end
        checks++; if (b_data !== '0) begin errors++; $display("[TB] FAIL nofalse_invalid_data: got %h expected 0", b_data); end
        in_valid = 1'b1;
        stall = 1'b1;
        @(posedge clk); #1;
        checks++; if (b_err !== 1'b0) begin errors++; $display("[TB] FAIL nofalse_stall: got %b expected 0", b_err); end
        stall = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        checks++; if (b_err !== 1'b0) begin errors++; $display("[TB] FAIL nofalse_flush: got %b expected 0", b_err); end
        flush = 1'b0;
    endtask

    task automatic test_async_reset();
        sel = 3'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        stall = 1'b1;
        checks++; if (a_valid !== 1'b1) begin errors++; $display("[TB] FAIL async_pre_valid: got %b expected 1", a_valid); end
        checks++; if (b_err !== 1'b1) begin errors++; $display("[TB] FAIL async_pre_err: got %b expected 1", b_err); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (a_data !== '0) begin errors++; $display("[TB] FAIL async_data: got %h expected 0", a_data); end
        checks++; if (a_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_valid: got %b expected 0", a_valid); end
        checks++; if (a_sel !== '0) begin errors++; $display("[TB] FAIL async_sel: got %h expected 0", a_sel); end
        checks++; if (b_err !== 1'b0) begin errors++; $display("[TB] FAIL async_err: got %b expected 0", b_err); end
        #2;
        rst_n = 1'b1;
        stall = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [2:0] s;
        logic v;
        logic [WIDTH-1:0] bexp;
        for (int k = 0; k < 16; k++) begin
            s = 3'($urandom_range(0, 7));
            v = 1'($urandom_range(0, 1));
            sel = s;
            in_valid = v;
            sbq.push_back('{data: 32'h1000_0000 + 32'(s), valid: v, sel: s, err: 1'b0});
            bexp = (s < 3'd6) ? 32'h1000_0000 + 32'(s) : 32'h0;
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++; if (a_data !== e.data) begin errors++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", k, a_data, e.data); end
            checks++; if (a_valid !== e.valid) begin errors++; $display("[TB] FAIL b2b_valid[%0d]: got %b expected %b", k, a_valid, e.valid); end
            checks++; if (a_sel !== e.sel) begin errors++; $display("[TB] FAIL b2b_sel[%0d]: got %h expected %h", k, a_sel, e.sel); end
            checks++; if (b_data !== bexp) begin errors++; $display("[TB] FAIL b2b_n6_data[%0d]: got %h expected %h", k, b_data, bexp); end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < NA; i++) begin
            in_data[i*WIDTH +: WIDTH] = 32'h1000_0000 + 32'(i);
        end
        test_reset();
`ifdef MUX_ONEHOT_EN
        test_onehot();
`else
        test_load();
        test_stall_flush();
        test_illegal();
        test_no_false_error();
        test_async_reset();
        test_back_to_back();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
